lsu_dma: RTL and testbench
==========================

LSU_DMA -- requirements
Module: lsu_dma

Interface
REQ-001 Parameter LEN_W, default 16, width of the word-count register.
REQ-002 Parameter TIMEOUT_CYC, default 16, maximum cycles to wait for i_data_vld per read.
REQ-003 Port i_clk  in  1  single clock; all state changes on its rising edge.
REQ-004 Port i_rst  in  1  reset; synchronous, active-high.
REQ-005 Port i_start  in  1  one-cycle request to begin a copy; sampled only in IDLE.
REQ-006 Port i_abort  in  1  cancels an active copy.
REQ-007 Ports i_src_addr, i_dst_addr  in  32 each  byte addresses; bits [1:0] ignored, forced to 0.
REQ-008 Port i_len  in  LEN_W  number of 32-bit words to copy.
REQ-009 Port o_busy  out  1  high whenever the FSM is not in IDLE.
REQ-010 Port o_done  out  1  one-cycle pulse when a copy ends, whether it ends normally or by timeout.
REQ-011 Port o_err  out  1  sticky timeout flag; cleared by the next accepted i_start.
REQ-012 Port o_lsu_addr  out  32  initiator-side address to the load/store unit.
REQ-013 Port o_st_data  out  32  store data.
REQ-014 Port o_st_strb  out  4  byte strobe; 4'hF during writes, 4'h0 otherwise.
REQ-015 Port o_lsu_wren  out  1  write enable; one cycle per word.
REQ-016 Port o_lsu_rden  out  1  read-request qualifier; high for the whole read wait.
REQ-017 Port i_ld_data  in  32  load data from the load/store unit.
REQ-018 Port i_data_vld  in  1  load data valid; the responder raises it one or more cycles after the read address.

Function
REQ-019 The FSM SHALL have the states IDLE, RD_REQ, RD_WAIT, WR and FIN.
REQ-020 In IDLE with i_start=1, the block SHALL latch src, dst and len, clear o_err and the timeout counter, and go to FIN if len==0, otherwise to RD_REQ.
REQ-021 RD_REQ: o_lsu_addr=src, o_lsu_rden=1, o_lsu_wren=0, then go to RD_WAIT unconditionally.
REQ-022 RD_WAIT: hold o_lsu_addr=src and o_lsu_rden=1, increment the timeout counter each cycle, and on i_data_vld=1 capture i_ld_data into the data register and go to WR.
REQ-023 If the counter reaches TIMEOUT_CYC-1 in RD_WAIT without i_data_vld, the block SHALL set o_err and go to FIN.
REQ-024 WR: o_lsu_addr=dst, o_st_data=data register, o_lsu_wren=1, o_st_strb=4'hF for exactly one cycle; then src+=4, dst+=4, len-=1, and the timeout counter clears.
REQ-025 From WR the block SHALL go to FIN if the remaining len is 0, otherwise to RD_REQ.
REQ-026 FIN: o_done=1 for one cycle, then go to IDLE.
REQ-027 Minimum throughput is 3 cycles per word (RD_REQ, RD_WAIT, WR) when i_data_vld arrives on the first RD_WAIT cycle.
REQ-028 Address arithmetic SHALL be modulo 2^32; 32'hFFFF_FFFC+4 wraps to 0 with no error.
REQ-029 i_start SHALL be ignored while o_busy=1.
REQ-030 i_data_vld SHALL be ignored outside RD_WAIT.
REQ-031 i_abort=1 in any non-IDLE state SHALL force IDLE on the next edge with no o_done and no further bus activity; a write in progress that cycle still completes.
REQ-032 i_abort SHALL take priority over the timeout and over i_data_vld.
REQ-033 In IDLE and FIN: o_lsu_wren=0, o_lsu_rden=0, o_st_strb=0, o_lsu_addr=0, o_st_data=0.
REQ-034 The block SHALL never assert o_lsu_wren and o_lsu_rden in the same cycle.

Reset
REQ-035 With i_rst=1 at a clock edge, the block SHALL enter IDLE, and o_busy, o_done, o_err, o_lsu_wren, o_lsu_rden, o_st_strb, o_lsu_addr and o_st_data SHALL all be 0; the counters and data register SHALL clear.
REQ-036 Reset during a copy SHALL abandon it with no o_done pulse.
REQ-037 i_rst SHALL override i_start and i_abort when asserted in the same cycle.

Verification
REQ-038 Scenario: src=0x2000, dst=0x2100, len=3, responder returns vld one cycle later with data 0xA0,0xA1,0xA2 -> writes to 0x2100/0x2104/0x2108 with data 0xA0/0xA1/0xA2 and strb F; a single o_done pulse; 9 busy cycles plus FIN.
REQ-039 Scenario: len=0 -> FIN on the next cycle, o_done pulse, and zero rden/wren cycles.
REQ-040 Scenario: TIMEOUT_CYC=16, responder never asserts vld -> o_err=1 and o_done pulse after 16 RD_WAIT cycles, and no write is issued.
REQ-041 Scenario: src=0xFFFF_FFFC, len=2 -> second read address is 0x0000_0000.
REQ-042 Scenario: i_abort asserted in RD_WAIT of word 2 of 4 -> IDLE next cycle, exactly 1 write seen, and no o_done.
REQ-043 Scenario: i_start pulses while busy, and spurious vld arrives in IDLE -> no effect on the copy in flight, and no bus activity from the spurious vld.

Source files
------------

// File: rtl/lsu_dma.sv
// Word-copy DMA engine driving a load/store unit: reads one word from src, writes it to dst,
// repeats for len words, with a per-read response timeout and abort.
module lsu_dma #(
  parameter int unsigned LEN_W       = 16,
  parameter int unsigned TIMEOUT_CYC = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic             i_abort,
  input  logic [31:0]      i_src_addr,
  input  logic [31:0]      i_dst_addr,
  input  logic [LEN_W-1:0] i_len,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_err,
  output logic [31:0]      o_lsu_addr,
  output logic [31:0]      o_st_data,
  output logic [3:0]       o_st_strb,
  output logic             o_lsu_wren,
  output logic             o_lsu_rden,
  input  logic [31:0]      i_ld_data,
  input  logic             i_data_vld
);

  localparam int unsigned CntW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(TIMEOUT_CYC - 1);

  typedef enum logic [2:0] {StIdle, StRdReq, StRdWait, StWr, StFin} state_e;

  state_e            state_q, state_d;
  logic [31:0]       src_q, src_d;
  logic [31:0]       dst_q, dst_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [31:0]       data_q, data_d;
  logic              err_q, err_d;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= StIdle;
      src_q   <= '0;
      dst_q   <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    dst_d   = dst_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    err_d   = err_q;
    case (state_q)
      StIdle: begin
        if (i_start) begin
          src_d   = i_src_addr & 32'hFFFF_FFFC;
          dst_d   = i_dst_addr & 32'hFFFF_FFFC;
          len_d   = i_len;
          cnt_d   = '0;
          err_d   = 1'b0;
          state_d = (i_len == '0) ? StFin : StRdReq;
        end
      end
      StRdReq: state_d = StRdWait;
      StRdWait: begin
        if (i_data_vld) begin
          data_d  = i_ld_data;
          state_d = StWr;
        end else if (cnt_q == CntMax) begin
          err_d   = 1'b1;
          cnt_d   = '0;
          state_d = StFin;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StWr: begin
        src_d   = src_q + 32'd4;
        dst_d   = dst_q + 32'd4;
        len_d   = len_q - LEN_W'(1);
        cnt_d   = '0;
        state_d = (len_q == LEN_W'(1)) ? StFin : StRdReq;
      end
      StFin:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
    // Abort wins over timeout and data; the write already on the bus this cycle still lands.
    if (i_abort && (state_q != StIdle)) begin
      state_d = StIdle;
      err_d   = err_q;
    end
  end

  always_comb begin
    o_busy     = (state_q != StIdle);
    o_done     = (state_q == StFin);
    o_err      = err_q;
    o_lsu_addr = '0;
    o_st_data  = '0;
    o_st_strb  = 4'h0;
    o_lsu_wren = 1'b0;
    o_lsu_rden = 1'b0;
    case (state_q)
      StRdReq, StRdWait: begin
        o_lsu_addr = src_q;
        o_lsu_rden = 1'b1;
      end
      StWr: begin
        o_lsu_addr = dst_q;
        o_st_data  = data_q;
        o_st_strb  = 4'hF;
        o_lsu_wren = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_lsu_dma.sv
// Directed self-checking bench for lsu_dma: copy, len=0, timeout, address wrap, abort, reset.
module tb_lsu_dma;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        i_start;
  logic        i_abort;
  logic [31:0] i_src_addr;
  logic [31:0] i_dst_addr;
  logic [15:0] i_len;
  logic        o_busy;
  logic        o_done;
  logic        o_err;
  logic [31:0] o_lsu_addr;
  logic [31:0] o_st_data;
  logic [3:0]  o_st_strb;
  logic        o_lsu_wren;
  logic        o_lsu_rden;
  logic [31:0] i_ld_data;
  logic        i_data_vld;

  int checks   = 0;
  int failures = 0;

  lsu_dma #(
    .LEN_W      (16),
    .TIMEOUT_CYC(16)
  ) dut (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_start   (i_start),
    .i_abort   (i_abort),
    .i_src_addr(i_src_addr),
    .i_dst_addr(i_dst_addr),
    .i_len     (i_len),
    .o_busy    (o_busy),
    .o_done    (o_done),
    .o_err     (o_err),
    .o_lsu_addr(o_lsu_addr),
    .o_st_data (o_st_data),
    .o_st_strb (o_st_strb),
    .o_lsu_wren(o_lsu_wren),
    .o_lsu_rden(o_lsu_rden),
    .i_ld_data (i_ld_data),
    .i_data_vld(i_data_vld)
  );

  always #5 i_clk = ~i_clk;

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_bus_quiet(input string tag);
    chk({tag, "_wren"}, 32'(o_lsu_wren), 32'd0);
    chk({tag, "_rden"}, 32'(o_lsu_rden), 32'd0);
    chk({tag, "_strb"}, 32'(o_st_strb), 32'd0);
    chk({tag, "_addr"}, o_lsu_addr, 32'd0);
    chk({tag, "_stdata"}, o_st_data, 32'd0);
  endtask

  int busy_cyc;
  int rd_cyc;
  int wr_cyc;
  int done_cnt;

  initial begin
    i_rst = 1'b1; i_start = 1'b0; i_abort = 1'b0;
    i_src_addr = '0; i_dst_addr = '0; i_len = '0;
    i_ld_data = '0; i_data_vld = 1'b0;
    tick(); tick();
    chk("rst_busy", 32'(o_busy), 32'd0);
    chk("rst_done", 32'(o_done), 32'd0);
    chk("rst_err", 32'(o_err), 32'd0);
    chk_bus_quiet("rst");
    i_rst = 1'b0;

    // Spurious valid while idle
    i_data_vld = 1'b1; i_ld_data = 32'hDEAD_BEEF;
    tick();
    i_data_vld = 1'b0; i_ld_data = '0;
    chk("spur_busy", 32'(o_busy), 32'd0);
    chk_bus_quiet("spur");

    // Three-word copy, with start pulsed while busy
    i_start = 1'b1; i_src_addr = 32'h2000; i_dst_addr = 32'h2100; i_len = 16'd3;
    busy_cyc = 0;
    tick();
    i_start = 1'b0;
    for (int w = 0; w < 3; w++) begin
      chk("cp_rdreq_addr", o_lsu_addr, 32'h2000 + 32'(4 * w));
      chk("cp_rdreq_rden", 32'(o_lsu_rden), 32'd1);
      chk("cp_rdreq_wren", 32'(o_lsu_wren), 32'd0);
      busy_cyc += int'(o_busy);
      i_start = 1'b1; i_src_addr = 32'h9000; i_dst_addr = 32'h9100; i_len = 16'd0;
      tick();
      i_start = 1'b0;
      chk("cp_wait_addr", o_lsu_addr, 32'h2000 + 32'(4 * w));
      chk("cp_wait_rden", 32'(o_lsu_rden), 32'd1);
      busy_cyc += int'(o_busy);
      i_data_vld = 1'b1; i_ld_data = 32'hA0 + 32'(w);
      tick();
      i_data_vld = 1'b0; i_ld_data = '0;
      chk("cp_wr_wren", 32'(o_lsu_wren), 32'd1);
      chk("cp_wr_rden", 32'(o_lsu_rden), 32'd0);
      chk("cp_wr_addr", o_lsu_addr, 32'h2100 + 32'(4 * w));
      chk("cp_wr_data", o_st_data, 32'hA0 + 32'(w));
      chk("cp_wr_strb", 32'(o_st_strb), 32'hF);
      chk("cp_wr_done", 32'(o_done), 32'd0);
      busy_cyc += int'(o_busy);
      tick();
    end
    chk("cp_fin_done", 32'(o_done), 32'd1);
    chk("cp_fin_busy", 32'(o_busy), 32'd1);
    chk("cp_fin_err", 32'(o_err), 32'd0);
    chk_bus_quiet("cp_fin");
    chk("cp_busy_cycles", 32'(busy_cyc), 32'd9);
    tick();
    chk("cp_idle_done", 32'(o_done), 32'd0);
    chk("cp_idle_busy", 32'(o_busy), 32'd0);

    // Zero-length copy goes straight to FIN
    i_start = 1'b1; i_src_addr = 32'h3000; i_dst_addr = 32'h3100; i_len = 16'd0;
    tick();
    i_start = 1'b0;
    chk("z_done", 32'(o_done), 32'd1);
    chk_bus_quiet("z_fin");
    tick();
    chk("z_idle_done", 32'(o_done), 32'd0);
    chk("z_idle_busy", 32'(o_busy), 32'd0);

    // Responder never answers: 16 wait cycles then FIN with error
    i_start = 1'b1; i_src_addr = 32'h4001; i_dst_addr = 32'h4100; i_len = 16'd1;
    tick();
    i_start = 1'b0;
    chk("to_rdreq_addr", o_lsu_addr, 32'h4000);
    tick();
    rd_cyc = 0; wr_cyc = 0;
    for (int i = 0; i < 40 && !o_done; i++) begin
      rd_cyc += int'(o_lsu_rden);
      wr_cyc += int'(o_lsu_wren);
      tick();
    end
    chk("to_done", 32'(o_done), 32'd1);
    chk("to_err", 32'(o_err), 32'd1);
    chk("to_wait_cycles", 32'(rd_cyc), 32'd16);
    chk("to_writes", 32'(wr_cyc), 32'd0);
    tick();
    chk("to_err_sticky", 32'(o_err), 32'd1);
    chk("to_idle_busy", 32'(o_busy), 32'd0);

    // Source wraps past the top of the address space; new start clears the error
    i_start = 1'b1; i_src_addr = 32'hFFFF_FFFC; i_dst_addr = 32'h5000; i_len = 16'd2;
    tick();
    i_start = 1'b0;
    chk("wr_err_clr", 32'(o_err), 32'd0);
    chk("wr_rd0_addr", o_lsu_addr, 32'hFFFF_FFFC);
    tick();
    i_data_vld = 1'b1; i_ld_data = 32'h55;
    tick();
    i_data_vld = 1'b0;
    chk("wr_wr0_addr", o_lsu_addr, 32'h5000);
    tick();
    chk("wr_rd1_addr", o_lsu_addr, 32'h0000_0000);
    chk("wr_rd1_rden", 32'(o_lsu_rden), 32'd1);
    tick();
    i_data_vld = 1'b1; i_ld_data = 32'h66;
    tick();
    i_data_vld = 1'b0;
    chk("wr_wr1_addr", o_lsu_addr, 32'h5004);
    chk("wr_wr1_data", o_st_data, 32'h66);
    tick();
    chk("wr_done", 32'(o_done), 32'd1);
    chk("wr_err", 32'(o_err), 32'd0);
    tick();

    // Abort in the read wait of word 2 of 4, together with valid
    i_start = 1'b1; i_src_addr = 32'h100; i_dst_addr = 32'h200; i_len = 16'd4;
    wr_cyc = 0; done_cnt = 0;
    tick();
    i_start = 1'b0;
    tick();
    i_data_vld = 1'b1; i_ld_data = 32'h11;
    tick();
    i_data_vld = 1'b0;
    wr_cyc += int'(o_lsu_wren);
    tick();
    chk("ab_rd1_addr", o_lsu_addr, 32'h104);
    tick();
    chk("ab_wait_rden", 32'(o_lsu_rden), 32'd1);
    i_abort = 1'b1; i_data_vld = 1'b1; i_ld_data = 32'h22;
    tick();
    i_abort = 1'b0; i_data_vld = 1'b0;
    chk("ab_busy", 32'(o_busy), 32'd0);
    chk("ab_done", 32'(o_done), 32'd0);
    chk_bus_quiet("ab");
    for (int i = 0; i < 4; i++) begin
      done_cnt += int'(o_done);
      wr_cyc += int'(o_lsu_wren);
      tick();
    end
    chk("ab_writes", 32'(wr_cyc), 32'd1);
    chk("ab_no_done", 32'(done_cnt), 32'd0);

    // Reset mid-copy overrides a simultaneous start and abort
    i_start = 1'b1; i_src_addr = 32'h600; i_dst_addr = 32'h700; i_len = 16'd2;
    tick();
    i_start = 1'b0;
    tick();
    i_rst = 1'b1; i_start = 1'b1; i_abort = 1'b1;
    tick();
    i_rst = 1'b0; i_start = 1'b0; i_abort = 1'b0;
    chk("rm_busy", 32'(o_busy), 32'd0);
    chk("rm_done", 32'(o_done), 32'd0);
    chk_bus_quiet("rm");
    tick();
    chk("rm_busy2", 32'(o_busy), 32'd0);
    chk("rm_done2", 32'(o_done), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
